// File: rtl/draw_scheduler.sv
// Shares raster scans of the 160x120 frame buffer between a full-frame redraw and an 8x8 tile redraw.
// Source addresses feed the colour lookup; a one-stage pipeline then drives the plot strobe.
module draw_scheduler #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int TILE  = 8,
  parameter int COL_W = 3
) (
  input  logic             clk50M,
  input  logic             rst_n,
  input  logic             req_frame,
  input  logic             req_tile,
  input  logic [4:0]       tile_col,
  input  logic [3:0]       tile_row,
  output logic             ack_frame,
  output logic             ack_tile,
  output logic             busy,
  output logic             done,
  output logic [7:0]       src_x,
  output logic [6:0]       src_y,
  input  logic [COL_W-1:0] src_colour,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  localparam int         TSH     = $clog2(TILE);
  localparam logic [7:0] X_LAST  = 8'(H_RES - 1);
  localparam logic [6:0] Y_LAST  = 7'(V_RES - 1);
  localparam logic [4:0] COL_MAX = 5'(H_RES / TILE - 1);
  localparam logic [3:0] ROW_MAX = 4'(V_RES / TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_TILE, S_FLUSH} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_src_x;
  logic [6:0] r_src_y;
  logic [4:0] r_col;
  logic       r_oor;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic       r_plot;
  logic       r_ack_frame, r_ack_tile, r_done;

  logic [7:0] w_base_x, w_rbase_x;
  logic [6:0] w_base_y;
  logic       w_tx_last, w_ty_last, w_frame_end;
  logic       w_ack_frame_d, w_ack_tile_d, w_done_d, w_valid;

  assign w_base_x    = 8'(tile_col) << TSH;
  assign w_base_y    = 7'(tile_row) << TSH;
  assign w_rbase_x   = 8'(r_col) << TSH;
  assign w_tx_last   = &r_src_x[TSH-1:0];
  assign w_ty_last   = &r_src_y[TSH-1:0];
  assign w_frame_end = (r_src_x == X_LAST) && (r_src_y == Y_LAST);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_frame)     w_state_nxt = S_FRAME;
        else if (req_tile) w_state_nxt = S_TILE;
      end
      S_FRAME: if (w_frame_end) w_state_nxt = S_FLUSH;
      S_TILE:  if (r_oor || (w_tx_last && w_ty_last)) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An out-of-range tile spends its single TILE cycle with no valid address.
  always_comb begin
    w_ack_frame_d = (r_state == S_IDLE) && req_frame;
    w_ack_tile_d  = (r_state == S_IDLE) && !req_frame && req_tile;
    w_done_d      = (r_state == S_FLUSH);
    w_valid       = (r_state == S_FRAME) || ((r_state == S_TILE) && !r_oor);
    busy          = (r_state != S_IDLE);
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_src_x <= '0;
      r_src_y <= '0;
      r_col   <= '0;
      r_oor   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_frame) begin
            r_src_x <= '0;
            r_src_y <= '0;
          end else if (req_tile) begin
            r_src_x <= w_base_x;
            r_src_y <= w_base_y;
            r_col   <= tile_col;
            r_oor   <= (tile_col > COL_MAX) || (tile_row > ROW_MAX);
          end
        end
        S_FRAME: begin
          if (r_src_x == X_LAST) begin
            r_src_x <= '0;
            r_src_y <= r_src_y + 7'd1;
          end else begin
            r_src_x <= r_src_x + 8'd1;
          end
        end
        S_TILE: begin
          if (w_tx_last) begin
            r_src_x <= w_rbase_x;
            r_src_y <= r_src_y + 7'd1;
          end else begin
            r_src_x <= r_src_x + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_plot      <= 1'b0;
      r_ack_frame <= 1'b0;
      r_ack_tile  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_x         <= r_src_x;
      r_y         <= r_src_y;
      r_plot      <= w_valid;
      r_ack_frame <= w_ack_frame_d;
      r_ack_tile  <= w_ack_tile_d;
      r_done      <= w_done_d;
    end
  end

  assign src_x     = r_src_x;
  assign src_y     = r_src_y;
  assign x         = r_x;
  assign y         = r_y;
  assign plot      = r_plot;
  assign colour    = src_colour;
  assign ack_frame = r_ack_frame;
  assign ack_tile  = r_ack_tile;
  assign done      = r_done;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a one-cycle colour lookup model.
`timescale 1ns/1ps
module tb_draw_scheduler;

  logic       clk50M = 1'b0;
  logic       rst_n;
  logic       req_frame, req_tile;
  logic [4:0] tile_col;
  logic [3:0] tile_row;
  logic       ack_frame, ack_tile, busy, done, plot;
  logic [7:0] src_x, x;
  logic [6:0] src_y, y;
  logic [2:0] src_colour, colour;

  int total = 0;
  int bad   = 0;

  draw_scheduler #(.H_RES(160), .V_RES(120), .TILE(8), .COL_W(3)) dut (
    .clk50M(clk50M), .rst_n(rst_n),
    .req_frame(req_frame), .req_tile(req_tile),
    .tile_col(tile_col), .tile_row(tile_row),
    .ack_frame(ack_frame), .ack_tile(ack_tile),
    .busy(busy), .done(done),
    .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk50M = ~clk50M;

  function automatic logic [2:0] cf(input int cx, input int cy);
    return 3'(cx * 3 + cy * 5 + (cx >> 3));
  endfunction

  // Colour lookup: result appears one cycle after the address.
  always @(posedge clk50M) src_colour <= cf(int'(src_x), int'(src_y));

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  // Starts in the first FRAME cycle; ends in the done cycle.
  task automatic scan_frame(input int raise_at, input logic [4:0] c, input logic [3:0] r);
    int ex, ey;
    for (int k = 0; k < 19200; k++) begin
      tick();
      ex = k % 160;
      ey = k / 160;
      if (plot !== 1'b1 || x !== 8'(ex) || y !== 7'(ey) || colour !== cf(ex, ey) ||
          busy !== 1'b1 || done !== 1'b0 || ack_tile !== 1'b0) begin
        bad++;
        $display("FAIL frame_pixel k=%0d: plot=%b x=%0d y=%0d col=%0d busy=%b done=%b ack_tile=%b, required plot=1 x=%0d y=%0d col=%0d busy=1 done=0 ack_tile=0",
                 k, plot, x, y, colour, busy, done, ack_tile, ex, ey, cf(ex, ey));
      end
      total++;
      if (k == raise_at) begin
        tile_col = c;
        tile_row = r;
        req_tile = 1'b1;
      end
    end
    tick();
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL frame_done: done=%b busy=%b plot=%b, required 1 0 0", done, busy, plot);
    end
    total++;
  endtask

  task automatic scan_tile(input int bx, input int by);
    int ex, ey;
    for (int k = 0; k < 64; k++) begin
      tick();
      ex = bx + k % 8;
      ey = by + k / 8;
      if (plot !== 1'b1 || x !== 8'(ex) || y !== 7'(ey) || colour !== cf(ex, ey) || busy !== 1'b1) begin
        bad++;
        $display("FAIL tile_pixel k=%0d: plot=%b x=%0d y=%0d col=%0d busy=%b, required plot=1 x=%0d y=%0d col=%0d busy=1",
                 k, plot, x, y, colour, busy, ex, ey, cf(ex, ey));
      end
      total++;
    end
    tick();
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL tile_done: done=%b busy=%b plot=%b, required 1 0 0", done, busy, plot);
    end
    total++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_frame = 1'b0; req_tile = 1'b0; tile_col = '0; tile_row = '0;
    tick(); tick();
    if ({src_x, src_y, x, y, ack_frame, ack_tile, busy, done, plot} !== '0) begin
      bad++;
      $display("FAIL reset_state: src=(%0d,%0d) xy=(%0d,%0d) ackf=%b ackt=%b busy=%b done=%b plot=%b, required all 0",
               src_x, src_y, x, y, ack_frame, ack_tile, busy, done, plot);
    end
    total++;
    rst_n = 1'b1;
    tick();
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
    total++;
  endtask

  task automatic test_reset_midframe();
    req_frame = 1'b1;
    tick();
    req_frame = 1'b0;
    repeat (837) tick();
    if (src_x !== 8'd37 || src_y !== 7'd5 || plot !== 1'b1 || x !== 8'd36) begin
      bad++;
      $display("FAIL midframe_addr: src=(%0d,%0d) plot=%b x=%0d, required (37,5) 1 36", src_x, src_y, plot, x);
    end
    total++;
    #2 rst_n = 1'b0;
    #1;
    if (plot !== 1'b0 || busy !== 1'b0 || src_x !== 8'd0 || src_y !== 7'd0) begin
      bad++;
      $display("FAIL async_reset: plot=%b busy=%b src=(%0d,%0d), required 0 0 (0,0)", plot, busy, src_x, src_y);
    end
    total++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
        bad++;
        $display("FAIL no_done_after_reset c=%0d: done=%b busy=%b plot=%b, required 0 0 0", i, done, busy, plot);
      end
      total++;
    end
    req_frame = 1'b1;
    tick();
    req_frame = 1'b0;
    if (ack_frame !== 1'b1 || src_x !== 8'd0 || src_y !== 7'd0) begin
      bad++;
      $display("FAIL restart_ack: ack_frame=%b src=(%0d,%0d), required 1 (0,0)", ack_frame, src_x, src_y);
    end
    total++;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (plot !== 1'b1 || x !== 8'(k) || y !== 7'd0) begin
        bad++;
        $display("FAIL restart_pixel k=%0d: plot=%b x=%0d y=%0d, required 1 %0d 0", k, plot, x, y, k);
      end
      total++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    if (ack_frame !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_pre: ack_frame=%b busy=%b, required 0 0", ack_frame, busy);
    end
    total++;
    req_frame = 1'b1;
    tick();
    req_frame = 1'b0;
    if (ack_frame !== 1'b1 || busy !== 1'b1 || ack_tile !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL frame_ack: ackf=%b busy=%b ackt=%b plot=%b, required 1 1 0 0", ack_frame, busy, ack_tile, plot);
    end
    total++;
    scan_frame(-1, '0, '0);
    tick();
    if (done !== 1'b0 || ack_frame !== 1'b0) begin
      bad++;
      $display("FAIL frame_done_pulse: done=%b ackf=%b, required 0 0", done, ack_frame);
    end
    total++;
  endtask

  task automatic test_tile_corner();
    tile_col = 5'd19; tile_row = 4'd14; req_tile = 1'b1;
    tick();
    req_tile = 1'b0; tile_col = 5'd0; tile_row = 4'd0;
    if (ack_tile !== 1'b1 || ack_frame !== 1'b0 || busy !== 1'b1 || src_x !== 8'd152 || src_y !== 7'd112) begin
      bad++;
      $display("FAIL corner_ack: ackt=%b ackf=%b busy=%b src=(%0d,%0d), required 1 0 1 (152,112)",
               ack_tile, ack_frame, busy, src_x, src_y);
    end
    total++;
    scan_tile(152, 112);
    tick();
  endtask

  task automatic test_simultaneous();
    tile_col = 5'd2; tile_row = 4'd3;
    req_frame = 1'b1; req_tile = 1'b1;
    tick();
    req_frame = 1'b0;
    if (ack_frame !== 1'b1 || ack_tile !== 1'b0) begin
      bad++;
      $display("FAIL simul_ack: ackf=%b ackt=%b, required 1 0", ack_frame, ack_tile);
    end
    total++;
    scan_frame(-1, '0, '0);
    tick();
    req_tile = 1'b0;
    if (ack_tile !== 1'b1 || busy !== 1'b1 || src_x !== 8'd16 || src_y !== 7'd24) begin
      bad++;
      $display("FAIL simul_tile_ack: ackt=%b busy=%b src=(%0d,%0d), required 1 1 (16,24)", ack_tile, busy, src_x, src_y);
    end
    total++;
    scan_tile(16, 24);
    tick();
  endtask

  task automatic test_tile_oor();
    tile_col = 5'd20; tile_row = 4'd0; req_tile = 1'b1;
    tick();
    req_tile = 1'b0;
    if (ack_tile !== 1'b1 || busy !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL oor_ack: ackt=%b busy=%b plot=%b done=%b, required 1 1 0 0", ack_tile, busy, plot, done);
    end
    total++;
    tick();
    if (busy !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL oor_mid: busy=%b plot=%b done=%b, required 1 0 0", busy, plot, done);
    end
    total++;
    tick();
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL oor_done: done=%b busy=%b plot=%b, required 1 0 0", done, busy, plot);
    end
    total++;
    tick();
  endtask

  task automatic test_tile_midframe();
    req_frame = 1'b1;
    tick();
    req_frame = 1'b0;
    if (ack_frame !== 1'b1) begin
      bad++;
      $display("FAIL mid_frame_ack: ackf=%b, required 1", ack_frame);
    end
    total++;
    scan_frame(100, 5'd5, 4'd1);
    tick();
    req_tile = 1'b0;
    if (ack_tile !== 1'b1 || src_x !== 8'd40 || src_y !== 7'd8) begin
      bad++;
      $display("FAIL mid_tile_ack: ackt=%b src=(%0d,%0d), required 1 (40,8)", ack_tile, src_x, src_y);
    end
    total++;
    scan_tile(40, 8);
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_frame();
    test_tile_corner();
    test_simultaneous();
    test_tile_oor();
    test_tile_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
